// File: rtl/pid_wb_pkg.sv
// Shared definitions for the PID Wishbone master.
//   - Byte addresses of the PID slave registers
//   - Sequencing FSM state encoding
//   - Width helper for the ack timeout counter
package pid_wb_pkg;

    localparam logic [7:0] ADR_KP = 8'h00;
    localparam logic [7:0] ADR_KI = 8'h04;
    localparam logic [7:0] ADR_KD = 8'h08;
    localparam logic [7:0] ADR_SP = 8'h0C;
    localparam logic [7:0] ADR_PV = 8'h10;
    localparam logic [7:0] ADR_UN = 8'h20;
    localparam logic [7:0] ADR_OF = 8'h28;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_KP, S_CFG_KI, S_CFG_KD, S_CFG_SP,
        S_WR_PV, S_RD_UN, S_RD_OF, S_GAP, S_DONE
    } state_t;

    // Bits needed to count 0..t (minimum 1).
    function automatic int cnt_width(input int t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/pid_wb_xfer.sv
// Single Wishbone classic-cycle transaction engine.
//   i_start          : launch a transaction with i_we/i_adr/i_wdata (ignored unless idle)
//   o_done           : combinational, high on the cycle the ack is sampled
//   o_timeout        : combinational, high on the last allowed wait cycle without ack
//   o_rdata          : read data captured on a read ack
//   o_wb_* / i_wb_*  : Wishbone master signals
// cyc/stb/we drop on the edge after the ack (or timeout); adr/data stay as issued.
module pid_wb_xfer import pid_wb_pkg::*; #(
    parameter int WB_NB   = 32,
    parameter int ADR_NB  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [ADR_NB-1:0] i_adr,
    input  logic [WB_NB-1:0]  i_wdata,
    output logic              o_done,
    output logic              o_timeout,
    output logic [WB_NB-1:0]  o_rdata,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADR_NB-1:0] o_wb_adr,
    output logic [WB_NB-1:0]  o_wb_data,
    input  logic              i_wb_ack,
    input  logic [WB_NB-1:0]  i_wb_data
);

    localparam int             CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    assign o_done    = o_wb_stb & i_wb_ack;
    // stb is high for exactly TIMEOUT cycles when the slave never answers
    assign o_timeout = o_wb_stb & ~i_wb_ack & (cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_adr  <= '0;
            o_wb_data <= '0;
            o_rdata   <= '0;
            cnt       <= '0;
        end else if (i_start && !o_wb_stb) begin
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= i_we;
            o_wb_adr  <= i_adr;
            o_wb_data <= i_wdata;
            cnt       <= '0;
        end else if (o_wb_stb) begin
            if (i_wb_ack || cnt == CNT_LAST) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
                o_wb_we  <= 1'b0;
                if (i_wb_ack && !o_wb_we) o_rdata <= i_wb_data;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pid_wb_master.sv
// Wishbone master sequencing the PID controller slave.
//   i_cfg_load, i_kp..i_sp : load gains and setpoint (writes 0x00..0x0C)
//   i_pv_valid/i_pv/o_pv_ready : process-variable sample handshake
//   o_un, o_of, o_valid    : u(n) and overflow readback, one-cycle update strobe
//   o_err                  : sticky ack timeout, cleared by the next config load
//   o_busy                 : sequence in progress
//   o_wb_* / i_wb_*        : Wishbone classic master port
module pid_wb_master import pid_wb_pkg::*; #(
    parameter int WB_NB   = 32,
    parameter int ADR_NB  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_load,
    input  logic [15:0]       i_kp,
    input  logic [15:0]       i_ki,
    input  logic [15:0]       i_kd,
    input  logic [15:0]       i_sp,
    input  logic              i_pv_valid,
    input  logic [15:0]       i_pv,
    output logic              o_pv_ready,
    output logic [WB_NB-1:0]  o_un,
    output logic [4:0]        o_of,
    output logic              o_valid,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADR_NB-1:0] o_wb_adr,
    output logic [WB_NB-1:0]  o_wb_data,
    input  logic              i_wb_ack,
    input  logic [WB_NB-1:0]  i_wb_data
);

    state_t state, state_n, ret, ret_n;

    logic [15:0]       ki_q, kd_q, sp_q;
    logic [WB_NB-1:0]  un_q;
    logic              x_start, x_we, x_done, x_timeout;
    logic [ADR_NB-1:0] x_adr;
    logic [WB_NB-1:0]  x_wdata, x_rdata;

    function automatic logic [WB_NB-1:0] sext(input logic [15:0] v);
        return {{(WB_NB-16){v[15]}}, v};
    endfunction

    function automatic logic is_bus(input state_t s);
        return s inside {S_CFG_KP, S_CFG_KI, S_CFG_KD, S_CFG_SP,
                         S_WR_PV, S_RD_UN, S_RD_OF};
    endfunction

    // State register and datapath registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
            ret   <= S_IDLE;
            ki_q  <= '0;
            kd_q  <= '0;
            sp_q  <= '0;
            un_q  <= '0;
            o_un  <= '0;
            o_of  <= '0;
            o_err <= 1'b0;
        end else begin
            state <= state_n;
            ret   <= ret_n;
            if (state == S_IDLE && i_cfg_load) begin
                ki_q  <= i_ki;
                kd_q  <= i_kd;
                sp_q  <= i_sp;
                o_err <= 1'b0;
            end
            if (x_timeout) o_err <= 1'b1;
            // GAP after RD_UN: the read register still holds u(n)
            if (state == S_GAP && ret == S_RD_OF) un_q <= x_rdata;
            // Entering DONE: publish both values together with o_valid
            if (state == S_GAP && ret == S_DONE) begin
                o_un <= un_q;
                o_of <= x_rdata[4:0];
            end
        end
    end

    // Next-state logic; ret holds the state that follows GAP
    always_comb begin
        state_n = state;
        ret_n   = ret;
        case (state)
            S_IDLE: begin
                if (i_cfg_load)      state_n = S_CFG_KP;
                else if (i_pv_valid) state_n = S_WR_PV;
            end
            S_CFG_KP, S_CFG_KI, S_CFG_KD, S_WR_PV, S_RD_UN, S_RD_OF: begin
                if (x_done) begin
                    state_n = S_GAP;
                    case (state)
                        S_CFG_KP: ret_n = S_CFG_KI;
                        S_CFG_KI: ret_n = S_CFG_KD;
                        S_CFG_KD: ret_n = S_CFG_SP;
                        S_WR_PV:  ret_n = S_RD_UN;
                        S_RD_UN:  ret_n = S_RD_OF;
                        default:  ret_n = S_DONE;
                    endcase
                end else if (x_timeout) begin
                    state_n = S_IDLE;
                end
            end
            S_CFG_SP: if (x_done || x_timeout) state_n = S_IDLE;
            S_GAP:    state_n = ret;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Transaction launch on entry to a bus state. kp and pv are only written
    // from IDLE, so they come straight from the inputs on the accepting edge.
    always_comb begin
        x_start = (state_n != state) && is_bus(state_n);
        x_we    = 1'b0;
        x_adr   = '0;
        x_wdata = '0;
        case (state_n)
            S_CFG_KP: begin x_we = 1'b1; x_adr = ADR_NB'(ADR_KP); x_wdata = sext(i_kp); end
            S_CFG_KI: begin x_we = 1'b1; x_adr = ADR_NB'(ADR_KI); x_wdata = sext(ki_q); end
            S_CFG_KD: begin x_we = 1'b1; x_adr = ADR_NB'(ADR_KD); x_wdata = sext(kd_q); end
            S_CFG_SP: begin x_we = 1'b1; x_adr = ADR_NB'(ADR_SP); x_wdata = sext(sp_q); end
            S_WR_PV:  begin x_we = 1'b1; x_adr = ADR_NB'(ADR_PV); x_wdata = sext(i_pv); end
            S_RD_UN:  x_adr = ADR_NB'(ADR_UN);
            S_RD_OF:  x_adr = ADR_NB'(ADR_OF);
            default:  ;
        endcase
    end

    assign o_valid    = (state == S_DONE);
    assign o_busy     = (state != S_IDLE);
    assign o_pv_ready = i_rst & (state == S_IDLE) & ~i_cfg_load;

    pid_wb_xfer #(.WB_NB(WB_NB), .ADR_NB(ADR_NB), .TIMEOUT(TIMEOUT)) u_xfer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (x_start),
        .i_we      (x_we),
        .i_adr     (x_adr),
        .i_wdata   (x_wdata),
        .o_done    (x_done),
        .o_timeout (x_timeout),
        .o_rdata   (x_rdata),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_adr  (o_wb_adr),
        .o_wb_data (o_wb_data),
        .i_wb_ack  (i_wb_ack),
        .i_wb_data (i_wb_data)
    );

endmodule

// File: tb/tb_pid_wb_master.sv
// Directed bench for pid_wb_master with a behavioural PID slave attached.
module tb_pid_wb_master;

    localparam int TO = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg = 1'b0, pv_valid = 1'b0;
    logic [15:0] kp = '0, ki = '0, kd = '0, sp = '0, pv = '0;
    logic        pv_ready, valid, err, busy;
    logic [31:0] un;
    logic [4:0]  of;
    logic        cyc, stb, we, ack;
    logic [15:0] adr;
    logic [31:0] wdat, rdat;

    always #5 clk = ~clk;

    pid_wb_master #(.WB_NB(32), .ADR_NB(16), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_cfg_load(cfg),
        .i_kp(kp), .i_ki(ki), .i_kd(kd), .i_sp(sp),
        .i_pv_valid(pv_valid), .i_pv(pv), .o_pv_ready(pv_ready),
        .o_un(un), .o_of(of), .o_valid(valid), .o_err(err), .o_busy(busy),
        .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_adr(adr),
        .o_wb_data(wdat), .i_wb_ack(ack), .i_wb_data(rdat)
    );

    // ---------------- PID slave model ----------------
    // Incremental PID; its history restarts whenever kp is written.
    // Reads stall while the post-pv computation lock is held.
    logic [15:0] s_kp, s_ki, s_kd, s_sp;
    int          s_u, s_e1, s_e2, s_e, lock;
    int          lock_len = 0;
    bit          hold_lock = 0, nack_pv = 0;
    logic [4:0]  s_of = '0;

    assign s_e = int'($signed(s_sp)) - int'($signed(wdat[15:0]));

    function automatic int pid_next(input int u, e, e1, e2, input logic [15:0] p16, i16, d16);
        int p, i, d;
        p = int'($signed(p16)); i = int'($signed(i16)); d = int'($signed(d16));
        return u + (p + i + d) * e - (p + 2 * d) * e1 + d * e2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= 1'b0; rdat <= '0; lock <= 0;
            s_kp <= '0; s_ki <= '0; s_kd <= '0; s_sp <= '0;
            s_u <= 0; s_e1 <= 0; s_e2 <= 0;
        end else begin
            ack <= 1'b0;
            if (!hold_lock && lock != 0) lock <= lock - 1;
            if (cyc && stb && !ack) begin
                if (we) begin
                    if (!(nack_pv && adr == 16'h0010)) begin
                        ack <= 1'b1;
                        case (adr)
                            16'h0000: begin s_kp <= wdat[15:0]; s_u <= 0; s_e1 <= 0; s_e2 <= 0; end
                            16'h0004: s_ki <= wdat[15:0];
                            16'h0008: s_kd <= wdat[15:0];
                            16'h000C: s_sp <= wdat[15:0];
                            16'h0010: begin
                                s_u  <= pid_next(s_u, s_e, s_e1, s_e2, s_kp, s_ki, s_kd);
                                s_e2 <= s_e1;
                                s_e1 <= s_e;
                                lock <= lock_len;
                            end
                            default: ;
                        endcase
                    end
                end else if (lock == 0 && !hold_lock) begin
                    ack  <= 1'b1;
                    rdat <= (adr == 16'h0020) ? 32'(s_u) : {27'b0, s_of};
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [15:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    int          viol = 0, valid_cnt = 0, un_cyc = 0, pv_cyc = 0;
    logic        p_stb = 0, p_ack = 0, p_we = 0;
    logic [15:0] p_adr = '0;
    logic [31:0] p_dat = '0;

    always @(negedge clk) begin
        p_stb <= stb; p_ack <= ack; p_we <= we; p_adr <= adr; p_dat <= wdat;
        if (rst_n) begin
            if (stb && ack) begin
                log_adr.push_back(adr); log_dat.push_back(wdat); log_we.push_back(we);
            end
            // stb must go low after an ack; request fields stable while waiting
            if ((p_stb && p_ack && stb) ||
                (p_stb && !p_ack && stb && (adr != p_adr || we != p_we || wdat != p_dat)))
                viol <= viol + 1;
            if (stb && adr == 16'h0020) un_cyc <= un_cyc + 1;
            if (stb && adr == 16'h0010) pv_cyc <= pv_cyc + 1;
            if (valid) valid_cnt <= valid_cnt + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        chk({name, " returns idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_cfg(input logic [15:0] p, i, d, s);
        @(negedge clk);
        kp = p; ki = i; kd = d; sp = s; cfg = 1'b1;
        @(negedge clk);
        cfg = 1'b0;
        kp = 16'hDEAD; ki = 16'hBEEF; kd = 16'hCAFE; sp = 16'hF00D;
        wait_idle("cfg");
    endtask

    // lat counts negedges from the accepting edge; 1 = first cycle in WR_PV
    task automatic do_sample(input logic [15:0] v, output int lat, output bit seen);
        int n;
        @(negedge clk);
        pv = v; pv_valid = 1'b1;
        n = 0;
        while (!pv_ready && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        pv_valid = 1'b0; pv = 16'h5A5A;
        lat = 1;
        while (!valid && busy && lat < 500) begin @(negedge clk); lat++; end
        seen = valid;
    endtask

    typedef struct {
        logic [15:0] pv;
        int          lock;
        logic [4:0]  of;
        logic [31:0] un;
        int          rd_cyc;
        int          lat;
    } smp_t;

    smp_t tab[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          base, lat, u0, v0, p0, n, bad;
        bit          seen;
        logic [15:0] exp_adr[4];
        logic [31:0] exp_dat[4];

        // kp=0x10 ki=2 kd=4 sp=0x100: k1=22, k2=kp+2kd=24, k3=4
        tab[0] = '{16'h00F0, 5, 5'h00, 32'h0000_0160, 5, 0};   // e=16
        tab[1] = '{16'h0100, 0, 5'h13, 32'hFFFF_FFE0, 2, 10};  // e=0 : 352-384
        tab[2] = '{16'h00FC, 2, 5'h01, 32'h0000_0078, 2, 0};   // e=4 : -32+88+64
        tab[3] = '{16'h0102, 0, 5'h1F, 32'hFFFF_FFEC, 2, 10};  // e=-2: 120-44-96
        exp_adr = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
        exp_dat = '{32'h0000_0010, 32'h0000_0002, 32'h0000_0004, 32'h0000_0100};

        // reset state
        repeat (3) @(negedge clk);
        chk("reset cyc/stb/we", {29'b0, cyc, stb, we}, 32'd0);
        chk("reset adr", 32'(adr), 32'd0);
        chk("reset wdata", wdat, 32'd0);
        chk("reset un", un, 32'd0);
        chk("reset of/valid/err/busy", {24'b0, of, valid, err, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", 32'(pv_ready), 32'd1);

        // config write sequence
        base = log_adr.size();
        do_cfg(16'h0010, 16'h0002, 16'h0004, 16'h0100);
        chk("cfg txn count", 32'(log_adr.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cfg%0d we/adr", i), {15'b0, log_we[base+i], log_adr[base+i]},
                {15'b0, 1'b1, exp_adr[i]});
            chk($sformatf("cfg%0d data", i), log_dat[base+i], exp_dat[i]);
        end

        // sample table
        for (int i = 0; i < 4; i++) begin
            lock_len = tab[i].lock; s_of = tab[i].of;
            u0 = un_cyc; v0 = valid_cnt;
            do_sample(tab[i].pv, lat, seen);
            chk($sformatf("smp%0d valid", i), 32'(seen), 32'd1);
            chk($sformatf("smp%0d un", i), un, tab[i].un);
            chk($sformatf("smp%0d of", i), 32'(of), 32'(tab[i].of));
            if (tab[i].lat != 0) chk($sformatf("smp%0d latency", i), 32'(lat), 32'(tab[i].lat));
            wait_idle("smp");
            @(negedge clk);
            chk($sformatf("smp%0d un read stb cycles", i), 32'(un_cyc - u0), 32'(tab[i].rd_cyc));
            chk($sformatf("smp%0d valid pulses", i), 32'(valid_cnt - v0), 32'd1);
        end

        // sign extension on kd
        base = log_adr.size();
        do_cfg(16'h0001, 16'h0000, 16'hFFFF, 16'h0000);
        chk("sext kd adr", 32'(log_adr[base+2]), 32'h8);
        chk("sext kd data", log_dat[base+2], 32'hFFFF_FFFF);

        // timeout on an un-acked pv write
        nack_pv = 1'b1;
        p0 = pv_cyc; v0 = valid_cnt;
        do_sample(16'h0050, lat, seen);
        @(negedge clk);
        chk("timeout stb cycles", 32'(pv_cyc - p0), 32'(TO));
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout no valid", 32'(valid_cnt - v0), 32'd0);
        chk("timeout ready", 32'(pv_ready), 32'd1);
        chk("timeout un kept", un, 32'hFFFF_FFEC);
        nack_pv = 1'b0;
        do_cfg(16'h0010, 16'h0002, 16'h0004, 16'h0100);
        chk("err cleared by cfg", 32'(err), 32'd0);

        // collision: config wins, sample waits
        base = log_adr.size();
        lock_len = 3; s_of = 5'h07;
        @(negedge clk);
        kp = 16'h0010; ki = 16'h0002; kd = 16'h0004; sp = 16'h0100;
        pv = 16'h00F0; cfg = 1'b1; pv_valid = 1'b1;
        #1;
        chk("collision ready low", 32'(pv_ready), 32'd0);
        @(negedge clk);
        cfg = 1'b0;
        bad = 0; n = 0;
        while (busy && n < 1000) begin
            if (pv_ready) bad++;
            @(negedge clk); n++;
        end
        chk("collision ready held low", 32'(bad), 32'd0);
        chk("collision ready after cfg", 32'(pv_ready), 32'd1);
        @(negedge clk);
        pv_valid = 1'b0;
        n = 0;
        while (!valid && n < 500) begin @(negedge clk); n++; end
        chk("collision un", un, 32'h0000_0160);
        chk("collision of", 32'(of), 32'h07);
        chk("collision order sp", 32'(log_adr[base+3]), 32'h0C);
        chk("collision order pv", 32'(log_adr[base+4]), 32'h10);
        wait_idle("collision");

        // reset while stalled in the u(n) read
        hold_lock = 1'b1; lock_len = 5;
        @(negedge clk);
        pv = 16'h00F8; pv_valid = 1'b1;
        @(negedge clk);
        pv_valid = 1'b0;
        n = 0;
        while (!(stb && adr == 16'h0020) && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("stalled in un read", {31'b0, stb && adr == 16'h0020}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst cyc/stb/we", {29'b0, cyc, stb, we}, 32'd0);
        chk("async rst adr", 32'(adr), 32'd0);
        chk("async rst wdata", wdat, 32'd0);
        chk("async rst un", un, 32'd0);
        chk("async rst of/valid/err/busy", {24'b0, of, valid, err, busy}, 32'd0);
        @(negedge clk);
        hold_lock = 1'b0; lock_len = 2; s_of = 5'h00;
        rst_n = 1'b1;
        do_cfg(16'h0010, 16'h0002, 16'h0004, 16'h0100);
        do_sample(16'h00F0, lat, seen);
        chk("post-reset valid", 32'(seen), 32'd1);
        chk("post-reset un", un, 32'h0000_0160);
        wait_idle("post-reset");

        @(negedge clk);
        chk("protocol violations", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
